// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
//   clock. A conversion takes WIDTH shift cycles plus one DONE cycle.
//
//   Parameters:
//     WIDTH  (4..32)  binary input width
//     DIGITS (1..10)  number of BCD output digits
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     start  conversion request, honoured only in IDLE
//     bin    binary operand, captured on the accepting edge
//     busy   high while shifting
//     done   one-cycle pulse, bcd/ovf updated on the same edge
//     bcd    result, digit k in bits [4k+3:4k]
//     ovf    value did not fit in DIGITS digits
//
//   Build option:
//     BCD_SATURATE_EN  defined   -> overflow saturates bcd to all 9s, ovf=1
//                      undefined -> no overflow logic, ovf tied 0, bcd is
//                                   the value mod 10^DIGITS
//
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_SHIFT | add-3 then shift one bit per cycle, WIDTH cycles
//   S_DONE  | result registered, done pulse, back to idle

module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BW-1:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]      bcd_q, bcd_d;

  logic [BW-1:0]      adj;
  logic [BW-1:0]      scratch_nxt;
  logic [WIDTH-1:0]   shift_nxt;

`ifdef BCD_SATURATE_EN
  logic               ovf_q, ovf_d;
  logic               ovf_sticky_q, ovf_sticky_d;
  logic               ovf_step;
  logic [4:0]         top_sum;
  logic [BW-1:0]      nines;
`endif

  // Datapath for one shift step: add-3 correction, then shift left by one.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_nxt = {adj[BW-2:0], shift_q[WIDTH-1]};
    shift_nxt   = {shift_q[WIDTH-2:0], 1'b0};
`ifdef BCD_SATURATE_EN
    // A 1 leaving the top digit, or a carry out of its correction, means the
    // value no longer fits in DIGITS digits.
    top_sum  = {1'b0, scratch_q[BW-1 -: 4]} + 5'd3;
    ovf_step = adj[BW-1] | ((scratch_q[BW-1 -: 4] >= 4'd5) & top_sum[4]);
    nines    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nines[4*i +: 4] = 4'd9;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
`ifdef BCD_SATURATE_EN
    ovf_d        = ovf_q;
    ovf_sticky_d = ovf_sticky_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
`ifdef BCD_SATURATE_EN
          ovf_sticky_d = 1'b0;
`endif
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d   = shift_nxt;
        scratch_d = scratch_nxt;
        cnt_d     = cnt_q - CNT_W'(1);
`ifdef BCD_SATURATE_EN
        ovf_sticky_d = ovf_sticky_q | ovf_step;
`endif
        // Last shift: load the outputs from the post-shift value directly.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
`ifdef BCD_SATURATE_EN
          if (ovf_sticky_q | ovf_step) begin
            bcd_d = nines;
            ovf_d = 1'b1;
          end else begin
            bcd_d = scratch_nxt;
            ovf_d = 1'b0;
          end
`else
          bcd_d = scratch_nxt;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
`ifdef BCD_SATURATE_EN
      ovf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
`ifdef BCD_SATURATE_EN
      ovf_q        <= ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
`endif
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign bcd  = bcd_q;
`ifdef BCD_SATURATE_EN
  assign ovf  = ovf_q;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq. Three instances: defaults (16b/5 digits),
// 16b/4 digits (overflow cases) and 8b/3 digits (exhaustive sweep).
// Expected results come from a decimal-arithmetic model.

module tb_bin_to_bcd_seq;

`ifdef BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start0, busy0, done0, ovf0;
  logic [15:0] bin0;
  logic [19:0] bcd0;
  logic        start1, busy1, done1, ovf1;
  logic [15:0] bin1;
  logic [15:0] bcd1;
  logic        start2, busy2, done2, ovf2;
  logic [7:0]  bin2;
  logic [11:0] bcd2;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .bin(bin0),
    .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int width_of(input int inst);
    return (inst == 2) ? 8 : 16;
  endfunction

  function automatic int digits_of(input int inst);
    case (inst)
      0:       return 5;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_done(input int inst);
    case (inst)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_ovf(input int inst);
    case (inst)
      0:       return ovf0;
      1:       return ovf1;
      default: return ovf2;
    endcase
  endfunction

  function automatic logic [39:0] get_bcd(input int inst);
    case (inst)
      0:       return 40'(bcd0);
      1:       return 40'(bcd1);
      default: return 40'(bcd2);
    endcase
  endfunction

  task automatic drive(input int inst, input logic s, input logic [31:0] v);
    case (inst)
      0:       begin start0 = s; bin0 = v[15:0]; end
      1:       begin start1 = s; bin1 = v[15:0]; end
      default: begin start2 = s; bin2 = v[7:0];  end
    endcase
  endtask

  // Reference: decimal digits of the value, saturated or taken mod 10^digits.
  function automatic logic [39:0] model_bcd(input longint v, input int digits);
    longint lim = 1;
    longint r;
    logic [39:0] b = '0;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (SAT && v >= lim) begin
      for (int i = 0; i < digits; i++) b[4*i +: 4] = 4'd9;
      return b;
    end
    r = v % lim;
    for (int i = 0; i < digits; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic logic model_ovf(input longint v, input int digits);
    longint lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return SAT && (v >= lim);
  endfunction

  // One full conversion with protocol checks; returns the registered result.
  task automatic convert(input int inst, input logic [31:0] v,
                         output logic [39:0] b, output logic o);
    logic [39:0] prev;
    logic        hold_err;
    int          n;
    hold_err = 1'b0;
    @(negedge clk);
    prev = get_bcd(inst);
    drive(inst, 1'b1, v);
    @(negedge clk);
    check("busy_after_accept", 40'(get_busy(inst)), 40'(1));
    drive(inst, 1'b0, $urandom);
    n = 0;
    while (!get_done(inst) && n < 100) begin
      if (get_bcd(inst) !== prev) hold_err = 1'b1;
      @(negedge clk);
      n++;
    end
    check("latency", 40'(n), 40'(width_of(inst)));
    check("busy_with_done", 40'(get_busy(inst)), 40'(0));
    b = get_bcd(inst);
    o = get_ovf(inst);
    @(negedge clk);
    check("done_one_cycle", 40'(get_done(inst)), 40'(0));
    check("bcd_hold_after", get_bcd(inst), b);
    check("bcd_hold_during", 40'(hold_err), 40'(0));
  endtask

  typedef struct {
    int          inst;
    logic [31:0] v;
    logic [39:0] eb;
    logic        eo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [39:0] b;
    logic        o;
    logic [31:0] v;
    int          n;
    int          cnt;

    vecs[0] = '{0, 32'h0037, 40'h00055, 1'b0};
    vecs[1] = '{0, 32'h0000, 40'h00000, 1'b0};
    vecs[2] = '{0, 32'hFFFF, 40'h65535, 1'b0};
    vecs[3] = '{1, 32'd12345, SAT ? 40'h9999 : 40'h2345, SAT};
    vecs[4] = '{1, 32'd9999, 40'h9999, 1'b0};
    vecs[5] = '{1, 32'd10000, SAT ? 40'h9999 : 40'h0000, SAT};
    vecs[6] = '{1, 32'd65535, SAT ? 40'h9999 : 40'h5535, SAT};
    vecs[7] = '{0, 32'd42, 40'h00042, 1'b0};
    vecs[8] = '{2, 32'd255, 40'h255, 1'b0};
    vecs[9] = '{2, 32'd0, 40'h000, 1'b0};

    reset = 1'b1;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    drive(2, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", 40'(busy0), 40'(0));
    check("rst_done", 40'(done0), 40'(0));
    check("rst_bcd", 40'(bcd0), 40'(0));
    check("rst_ovf", 40'(ovf0), 40'(0));
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].inst, vecs[i].v, b, o);
      check($sformatf("vec%0d_bcd", i), b, vecs[i].eb);
      check($sformatf("vec%0d_ovf", i), 40'(o), 40'(vecs[i].eo));
    end

    // Back-to-back with start held high throughout.
    @(negedge clk);
    drive(0, 1'b1, 0);
    @(negedge clk);
    check("b2b_accept0", 40'(busy0), 40'(1));
    bin0 = 16'hFFFF;
    n = 0;
    while (!done0 && n < 100) begin @(negedge clk); n++; end
    check("b2b_lat0", 40'(n), 40'(16));
    check("b2b_bcd0", 40'(bcd0), 40'h00000);
    @(negedge clk);
    check("b2b_idle_gap", 40'({busy0, done0}), 40'(0));
    @(negedge clk);
    check("b2b_accept1", 40'(busy0), 40'(1));
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 100) begin @(negedge clk); n++; end
    check("b2b_lat1", 40'(n), 40'(16));
    check("b2b_bcd1", 40'(bcd0), 40'h65535);
    cnt = 0;
    repeat (25) begin @(negedge clk); if (done0 || busy0) cnt++; end
    check("b2b_no_extra", 40'(cnt), 40'(0));

    // Reset in the middle of a conversion.
    @(negedge clk);
    drive(0, 1'b1, 1234);
    @(negedge clk);
    drive(0, 1'b0, 0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 40'(busy0), 40'(0));
    check("abort_done", 40'(done0), 40'(0));
    check("abort_bcd", 40'(bcd0), 40'(0));
    cnt = 0;
    repeat (25) begin @(negedge clk); if (done0) cnt++; end
    check("abort_no_done", 40'(cnt), 40'(0));
    convert(0, 42, b, o);
    check("after_abort_bcd", b, 40'h00042);

    // Random operands against the model.
    for (int i = 0; i < 30; i++) begin
      v = 32'($urandom_range(0, 65535));
      convert(0, v, b, o);
      check("rnd0_bcd", b, model_bcd(longint'(v), 5));
      check("rnd0_ovf", 40'(o), 40'(model_ovf(longint'(v), 5)));
    end
    for (int i = 0; i < 30; i++) begin
      v = (i % 2 == 0) ? 32'($urandom_range(0, 9999)) : 32'($urandom_range(0, 65535));
      convert(1, v, b, o);
      check("rnd1_bcd", b, model_bcd(longint'(v), 4));
      check("rnd1_ovf", 40'(o), 40'(model_ovf(longint'(v), 4)));
    end

    // Exhaustive 8-bit sweep.
    for (int i = 0; i < 256; i++) begin
      convert(2, 32'(i), b, o);
      check("sweep_bcd", b, model_bcd(longint'(i), 3));
      check("sweep_ovf", 40'(o), 40'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
